ctr_ndigit_updown_sseg: RTL

CTR_NDIGIT_UPDOWN_SSEG -- requirements
Module: ctr_ndigit_updown_sseg

---
 rtl/ctr_ndigit_updown_sseg_pkg.sv | 40 ++++
 rtl/ctr_bcd_updown_digit.sv | 48 ++++
 rtl/ctr_ndigit_updown_sseg.sv | 82 ++++++++
 3 files changed

// File: rtl/ctr_ndigit_updown_sseg_pkg.sv
// Shared constants for the N-digit BCD up/down counter with seven-segment
// outputs. The package holds the active-low segment codes for 0-9, the blank
// code and the BCD digit limits, plus a small decoder function.
package ctr_ndigit_updown_sseg_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK; // digits are kept in 0-9, so unreachable
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ctr_bcd_updown_digit.sv
// One BCD digit of the up/down counter.
//   clk    : clock, rising edge
//   ar     : synchronous active-low reset (digit -> 0)
//   en_in  : advance this digit this cycle (carry/borrow from lower digits)
//   up     : 1 = increment, 0 = decrement
//   load   : parallel load of d (values above 9 load as 0), beats en_in
//   d      : load value
//   q      : current digit
//   tc_out : digit sits at its terminal value for the current direction
module ctr_bcd_updown_digit
  import ctr_ndigit_updown_sseg_pkg::*;
(
  input  logic       clk,
  input  logic       ar,
  input  logic       en_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc_out
);

  logic [3:0] q_d;
  logic [3:0] q_q;

  // NOTE: q_d gets a default before any branch so no path leaves it
  // unassigned; that is what keeps this block free of latches.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (d > BCD_MAX) ? BCD_MIN : d;
    end else if (en_in) begin
      if (up) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else    q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!ar) q_q <= BCD_MIN;
    else     q_q <= q_d;
  end

  assign q      = q_q;
  assign tc_out = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

endmodule

// File: rtl/ctr_ndigit_updown_sseg.sv
// N-digit decimal up/down counter with active-low seven-segment outputs.
//   clk      : clock, rising edge
//   ar       : synchronous active-low reset (count and ovf -> 0)
//   e_in     : count enable, active-low
//   up       : 1 = increment, 0 = decrement
//   load     : synchronous parallel load, beats counting
//   load_val : BCD load value, digit 0 in [3:0]
//   bcd      : registered count
//   leds     : segments, digit i in [7i+6:7i], optional leading-zero blanking
//   tc       : combinational terminal count for the current direction
//   ovf      : one-cycle pulse after any count cycle taken while tc = 1
module ctr_ndigit_updown_sseg
  import ctr_ndigit_updown_sseg_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter bit WRAP     = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  ar,
  input  logic                  e_in,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   leds,
  output logic                  tc,
  output logic                  ovf
);

  logic [DIGITS-1:0] en_chain;
  logic [DIGITS-1:0] dig_tc;
  logic              count_req;
  logic              ovf_d;
  logic              ovf_q;

  assign count_req = ~e_in & ~load;
  assign tc        = &dig_tc;

  // In saturate mode the terminal state simply stops the chain at digit 0;
  // ovf still fires because a count cycle was taken at the boundary.
  assign en_chain[0] = count_req & (WRAP | ~tc);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_carry
      // Digit i moves only when every lower digit is at its terminal value.
      assign en_chain[i] = en_chain[i-1] & dig_tc[i-1];
    end

    ctr_bcd_updown_digit u_digit (
      .clk    (clk),
      .ar     (ar),
      .en_in  (en_chain[i]),
      .up     (up),
      .load   (load),
      .d      (load_val[4*i +: 4]),
      .q      (bcd[4*i +: 4]),
      .tc_out (dig_tc[i])
    );
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_decode
    if (i == 0) begin : g_lsd
      assign leds[6:0] = seg_encode(bcd[3:0]);
    end else begin : g_upper
      // Blank when this digit and everything above it are zero.
      logic blank;
      assign blank = BLANK_LZ && (bcd[4*DIGITS-1:4*i] == '0);
      assign leds[7*i +: 7] = blank ? SEG_BLANK : seg_encode(bcd[4*i +: 4]);
    end
  end

  assign ovf_d = count_req & tc;

  always_ff @(posedge clk) begin
    if (!ar) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule
